// File: rtl/up_sample_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// Package: up_sample_ctrl_pkg
// Purpose: Shared types and constants for the up_sample affine loop-nest
//          controller (up_sample_affine_ctrl) and its interface.
// Contents:
//   CTRL_W_DEFAULT  default width of each loop index
//   NUM_DIMS        depth of the loop nest (outer, middle, inner)
//   ctrl_state_t    controller FSM states
// -----------------------------------------------------------------------------
package up_sample_ctrl_pkg;

    localparam int CTRL_W_DEFAULT = 16;
    localparam int NUM_DIMS       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/up_sample_affine_ctrl_if.sv
// -----------------------------------------------------------------------------
// Interface: up_sample_affine_ctrl_if
// Purpose: Bundles the control/status signals of one affine loop-nest
//          controller driving a unified-buffer wen/ren port.
// Signals:
//   start      begin one traversal (sampled only in IDLE)
//   flush      synchronous abort, same effect as reset
//   stall      hold the iteration (present only when CTRL_STALL_EN is defined)
//   en         one point issued per high cycle
//   ctrl_vars  loop indices, [0]=outer .. [2]=inner
//   busy       high during DELAY and RUN
//   done       one-cycle pulse after the last point
// Modports:
//   master     the controller (drives en/ctrl_vars/busy/done)
//   slave      the side issuing start/flush/stall
// Configuration macro: CTRL_STALL_EN
// -----------------------------------------------------------------------------
interface up_sample_affine_ctrl_if
    import up_sample_ctrl_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEFAULT
);

    logic                               start;
    logic                               flush;
`ifdef CTRL_STALL_EN
    logic                               stall;
`endif
    logic                               en;
    logic [NUM_DIMS-1:0][CTRL_W-1:0]    ctrl_vars;
    logic                               busy;
    logic                               done;

    modport master (
        input  start,
        input  flush,
`ifdef CTRL_STALL_EN
        input  stall,
`endif
        output en,
        output ctrl_vars,
        output busy,
        output done
    );

    modport slave (
        output start,
        output flush,
`ifdef CTRL_STALL_EN
        output stall,
`endif
        input  en,
        input  ctrl_vars,
        input  busy,
        input  done
    );

endinterface

// File: rtl/affine_dim_counter.sv
// -----------------------------------------------------------------------------
// Module: affine_dim_counter
// Purpose: One dimension of the affine loop nest. Counts 0..EXT-1 on each
//          i_inc and flags the wrap so the next-outer dimension can carry.
// Parameters:
//   EXT      extent of this dimension (>= 1)
//   CTRL_W   index width
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_inc    in   advance the index this cycle
//   i_clr    in   synchronous clear (takes priority over i_inc)
//   o_idx    out  current index
//   o_wrap   out  i_inc && o_idx == EXT-1 (carry into the outer dimension)
// -----------------------------------------------------------------------------
module affine_dim_counter #(
    parameter int EXT    = 128,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_inc,
    input  logic              i_clr,
    output logic [CTRL_W-1:0] o_idx,
    output logic              o_wrap
);

    localparam logic [CTRL_W-1:0] LAST = CTRL_W'(EXT - 1);

    logic [CTRL_W-1:0] r_idx;

    // With EXT=1 the index stays 0 and every increment is a carry.
    assign o_wrap = i_inc && (r_idx == LAST);
    assign o_idx  = r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (i_clr || o_wrap) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= r_idx + CTRL_W'(1);
        end
    end

endmodule

// File: rtl/up_sample_affine_ctrl.sv
// -----------------------------------------------------------------------------
// Module: up_sample_affine_ctrl
// Purpose: Initiator side of the unified-buffer port protocol. Walks a 3-deep
//          affine loop nest (EXT0 x EXT1 x EXT2, inner stride 1) and raises en
//          for one cycle per point, with the matching indices on ctrl_vars.
//          An optional START_DELAY idle period precedes the first point and a
//          one-cycle done pulse follows the last.
// Parameters:
//   CTRL_W       index/counter width
//   EXT0..EXT2   loop extents, outer..inner (1 <= EXTn <= 2**CTRL_W)
//   START_DELAY  idle cycles between accepted start and first point
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   bus          up_sample_affine_ctrl_if.master
//                (start, flush, [stall] in; en, ctrl_vars, busy, done out)
// Configuration macro: CTRL_STALL_EN
//   defined   : bus.stall=1 in RUN suppresses en and freezes the counters
//   undefined : no stall input, RUN issues one point every cycle
// -----------------------------------------------------------------------------
module up_sample_affine_ctrl
    import up_sample_ctrl_pkg::*;
#(
    parameter int CTRL_W      = CTRL_W_DEFAULT,
    parameter int EXT0        = 1,
    parameter int EXT1        = 128,
    parameter int EXT2        = 128,
    parameter int START_DELAY = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    up_sample_affine_ctrl_if.master bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_DELAY = DELAY;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam longint EXT_MAX      = longint'(1) << CTRL_W;
    localparam int     DLY_W        = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int     DLY_LAST_INT = (START_DELAY > 0) ? START_DELAY - 1 : 0;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY_LAST_INT);

    if (EXT0 < 1 || EXT1 < 1 || EXT2 < 1 ||
        longint'(EXT0) > EXT_MAX || longint'(EXT1) > EXT_MAX || longint'(EXT2) > EXT_MAX) begin : g_bad_ext
        $error("up_sample_affine_ctrl: every EXTn must be in 1..2**CTRL_W");
    end

    logic [1:0]                      r_state;
    logic [DLY_W-1:0]                r_delay;
    logic                            w_stall;
    logic                            w_en;
    logic [NUM_DIMS-1:0][CTRL_W-1:0] w_idx;
    logic [NUM_DIMS-1:0]             w_wrap;

`ifdef CTRL_STALL_EN
    assign w_stall = bus.stall;
`else
    assign w_stall = 1'b0;
`endif

    // A point is issued (and the counters advance) on every un-stalled RUN cycle.
    assign w_en = (r_state == ST_RUN) && !w_stall;

    // Inner dimension advances on en; each outer one advances on the carry
    // from the dimension inside it. flush clears all indices back to 0.
    affine_dim_counter #(.EXT(EXT2), .CTRL_W(CTRL_W)) u_dim2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_en),
        .i_clr  (bus.flush),
        .o_idx  (w_idx[2]),
        .o_wrap (w_wrap[2])
    );

    affine_dim_counter #(.EXT(EXT1), .CTRL_W(CTRL_W)) u_dim1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_wrap[2]),
        .i_clr  (bus.flush),
        .o_idx  (w_idx[1]),
        .o_wrap (w_wrap[1])
    );

    affine_dim_counter #(.EXT(EXT0), .CTRL_W(CTRL_W)) u_dim0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_wrap[1]),
        .i_clr  (bus.flush),
        .o_idx  (w_idx[0]),
        .o_wrap (w_wrap[0])
    );

    // Carry out of the outer dimension marks the last point of the nest; all
    // counters have wrapped to 0 by the time DONE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_delay <= '0;
        end else if (bus.flush) begin
            r_state <= ST_IDLE;
            r_delay <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_delay <= '0;
                        r_state <= (START_DELAY > 0) ? ST_DELAY : ST_RUN;
                    end
                end
                ST_DELAY: begin
                    if (r_delay == DLY_LAST) begin
                        r_delay <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_delay <= r_delay + DLY_W'(1);
                    end
                end
                ST_RUN: begin
                    if (w_wrap[0]) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.en        = w_en;
    assign bus.ctrl_vars = w_idx;
    assign bus.busy      = (r_state == ST_DELAY) || (r_state == ST_RUN);
    assign bus.done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_up_sample_affine_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench: tb_up_sample_affine_ctrl
// Exercises up_sample_affine_ctrl in three configurations:
//   dutA  EXT=(1,4,4) START_DELAY=0
//   dutB  EXT=(2,2,3) START_DELAY=5
//   dutC  EXT=(1,1,4) START_DELAY=0 (only when CTRL_STALL_EN is defined)
// Expected outputs come from a timeline model: a traversal whose start was
// sampled at edge k shows DELAY for t=1..D, point p=t-D-1 for t=D+1..D+N and
// done at t=D+N+1, where t counts cycles after edge k.
// Configuration macro: CTRL_STALL_EN
// -----------------------------------------------------------------------------
module tb_up_sample_affine_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    up_sample_affine_ctrl_if #(.CTRL_W(16)) ifA ();
    up_sample_affine_ctrl_if #(.CTRL_W(16)) ifB ();

    up_sample_affine_ctrl #(
        .CTRL_W(16), .EXT0(1), .EXT1(4), .EXT2(4), .START_DELAY(0)
    ) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA)
    );

    up_sample_affine_ctrl #(
        .CTRL_W(16), .EXT0(2), .EXT1(2), .EXT2(3), .START_DELAY(5)
    ) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB)
    );

    // Observed outputs packed as {en, busy, done, ctrl[0], ctrl[1], ctrl[2]}.
    logic [50:0] obsA;
    logic [50:0] obsB;
    assign obsA = {ifA.en, ifA.busy, ifA.done, ifA.ctrl_vars[0], ifA.ctrl_vars[1], ifA.ctrl_vars[2]};
    assign obsB = {ifB.en, ifB.busy, ifB.done, ifB.ctrl_vars[0], ifB.ctrl_vars[1], ifB.ctrl_vars[2]};

`ifdef CTRL_STALL_EN
    up_sample_affine_ctrl_if #(.CTRL_W(16)) ifC ();

    up_sample_affine_ctrl #(
        .CTRL_W(16), .EXT0(1), .EXT1(1), .EXT2(4), .START_DELAY(0)
    ) dutC (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifC)
    );

    logic [50:0] obsC;
    assign obsC = {ifC.en, ifC.busy, ifC.done, ifC.ctrl_vars[0], ifC.ctrl_vars[1], ifC.ctrl_vars[2]};
`endif

    // Timeline reference: expected output vector t cycles after the start edge.
    function automatic logic [50:0] expect_vec(int e0, int e1, int e2, int d, bit act, int t);
        int n;
        int p;
        n = e0 * e1 * e2;
        expect_vec = '0;
        if (act && t >= 1 && t <= d) begin
            expect_vec = {3'b010, 48'd0};
        end else if (act && t > d && t <= d + n) begin
            p = t - d - 1;
            expect_vec = {3'b110, 16'(p / (e1 * e2)), 16'((p / e2) % e1), 16'(p % e2)};
        end else if (act && t == d + n + 1) begin
            expect_vec = {3'b001, 48'd0};
        end
    endfunction

    // Advance to just after the next rising edge; cyc then names the cycle
    // that edge opened, so the edge just crossed is cyc-1.
    task automatic nextCycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        total++;
        if (obsA !== 51'd0) begin
            bad++;
            $display("[TB] FAIL reset_A got=%h want=0", obsA);
        end
        total++;
        if (obsB !== 51'd0) begin
            bad++;
            $display("[TB] FAIL reset_B got=%h want=0", obsB);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) nextCycle();
        total++;
        if ({obsA, obsB} !== 102'd0) begin
            bad++;
            $display("[TB] FAIL idle_after_reset got=%h/%h want=0/0", obsA, obsB);
        end
    endtask

    task automatic test_single_traversal();
        int k;
        logic [50:0] e;
        ifA.start = 1'b1;
        nextCycle();
        k = cyc - 1;
        ifA.start = 1'b0;
        for (int i = 0; i < 19; i++) begin
            e = expect_vec(1, 4, 4, 0, 1'b1, cyc - k);
            total++;
            if (obsA !== e) begin
                bad++;
                $display("[TB] FAIL single t=%0d got=%h want=%h", cyc - k, obsA, e);
            end
            nextCycle();
        end
    endtask

    task automatic test_delayed_start();
        int k;
        logic [50:0] e;
        ifB.start = 1'b1;
        nextCycle();
        k = cyc - 1;
        ifB.start = 1'b0;
        for (int i = 0; i < 21; i++) begin
            e = expect_vec(2, 2, 3, 5, 1'b1, cyc - k);
            total++;
            if (obsB !== e) begin
                bad++;
                $display("[TB] FAIL delayed t=%0d got=%h want=%h", cyc - k, obsB, e);
            end
            nextCycle();
        end
    endtask

    // Re-pulse start in RUN (t=5) and DONE (t=17); the pulse at t=18 lands
    // in IDLE and must launch a second traversal from edge k+18.
    task automatic test_ignored_start();
        int k;
        int t;
        int enCount;
        int doneCount;
        logic [50:0] e;
        enCount = 0;
        doneCount = 0;
        ifA.start = 1'b1;
        nextCycle();
        k = cyc - 1;
        ifA.start = 1'b0;
        for (int i = 0; i < 38; i++) begin
            t = cyc - k;
            e = (t <= 18) ? expect_vec(1, 4, 4, 0, 1'b1, t) : expect_vec(1, 4, 4, 0, 1'b1, t - 18);
            total++;
            if (obsA !== e) begin
                bad++;
                $display("[TB] FAIL ignored_start t=%0d got=%h want=%h", t, obsA, e);
            end
            if (ifA.en === 1'b1) enCount++;
            if (ifA.done === 1'b1) doneCount++;
            ifA.start = (t == 5 || t == 17 || t == 18);
            nextCycle();
        end
        ifA.start = 1'b0;
        total++;
        if (enCount != 32 || doneCount != 2) begin
            bad++;
            $display("[TB] FAIL back_to_back en=%0d done=%0d want en=32 done=2", enCount, doneCount);
        end
    endtask

    task automatic test_flush();
        int k;
        int t;
        int enCount;
        logic [50:0] e;
        ifA.start = 1'b1;
        nextCycle();
        k = cyc - 1;
        ifA.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            t = cyc - k;
            e = (t <= 7) ? expect_vec(1, 4, 4, 0, 1'b1, t) : 51'd0;
            total++;
            if (obsA !== e) begin
                bad++;
                $display("[TB] FAIL flush t=%0d got=%h want=%h", t, obsA, e);
            end
            ifA.flush = (t == 7);
            nextCycle();
        end
        ifA.flush = 1'b0;
        enCount = 0;
        ifA.start = 1'b1;
        nextCycle();
        k = cyc - 1;
        ifA.start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            e = expect_vec(1, 4, 4, 0, 1'b1, cyc - k);
            total++;
            if (obsA !== e) begin
                bad++;
                $display("[TB] FAIL after_flush t=%0d got=%h want=%h", cyc - k, obsA, e);
            end
            if (ifA.en === 1'b1) enCount++;
            nextCycle();
        end
        total++;
        if (enCount != 16) begin
            bad++;
            $display("[TB] FAIL after_flush_points got=%0d want=16", enCount);
        end
    endtask

    task automatic test_async_reset();
        int k;
        logic [50:0] e;
        ifB.start = 1'b1;
        nextCycle();
        k = cyc - 1;
        ifB.start = 1'b0;
        nextCycle();
        nextCycle();
        e = expect_vec(2, 2, 3, 5, 1'b1, cyc - k);
        total++;
        if (obsB !== e) begin
            bad++;
            $display("[TB] FAIL pre_reset_delay got=%h want=%h", obsB, e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obsB !== 51'd0) begin
            bad++;
            $display("[TB] FAIL async_reset got=%h want=0", obsB);
        end
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            total++;
            if (obsB !== 51'd0) begin
                bad++;
                $display("[TB] FAIL idle_after_async got=%h want=0", obsB);
            end
        end
        ifB.start = 1'b1;
        nextCycle();
        k = cyc - 1;
        ifB.start = 1'b0;
        for (int i = 0; i < 21; i++) begin
            e = expect_vec(2, 2, 3, 5, 1'b1, cyc - k);
            total++;
            if (obsB !== e) begin
                bad++;
                $display("[TB] FAIL restart_after_reset t=%0d got=%h want=%h", cyc - k, obsB, e);
            end
            nextCycle();
        end
    endtask

    // Random start/flush traffic on dutB; the model accepts start only when
    // no traversal is in DELAY/RUN/DONE, and flush drops any traversal.
    task automatic test_random();
        bit act;
        bit st;
        bit fl;
        int k;
        int t;
        logic [50:0] e;
        act = 1'b0;
        k = 0;
        for (int i = 0; i < 400; i++) begin
            t = cyc - k;
            e = expect_vec(2, 2, 3, 5, act, t);
            total++;
            if (obsB !== e) begin
                bad++;
                $display("[TB] FAIL random cyc=%0d got=%h want=%h", cyc, obsB, e);
            end
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 59) == 0);
            ifB.start = st;
            ifB.flush = fl;
            if (fl) begin
                act = 1'b0;
            end else if (st && (!act || t > 5 + 12 + 1)) begin
                act = 1'b1;
                k = cyc;
            end
            nextCycle();
        end
        ifB.start = 1'b0;
        ifB.flush = 1'b0;
        nextCycle();
    endtask

`ifdef CTRL_STALL_EN
    task automatic test_stall();
        int k;
        int t;
        int pts;
        bit s;
        logic [50:0] e;
        bit enPat [6];
        int idxPat [6];
        enPat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        idxPat = '{0, 1, 1, 1, 2, 3};
        ifC.start = 1'b1;
        nextCycle();
        k = cyc - 1;
        ifC.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            t = cyc - k;
            ifC.stall = (t == 2 || t == 3);
            #1;
            e = {enPat[i], 1'b1, 1'b0, 32'd0, 16'(idxPat[i])};
            total++;
            if (obsC !== e) begin
                bad++;
                $display("[TB] FAIL stall_directed t=%0d got=%h want=%h", t, obsC, e);
            end
            nextCycle();
        end
        ifC.stall = 1'b0;
        #1;
        total++;
        if (obsC !== {3'b001, 48'd0}) begin
            bad++;
            $display("[TB] FAIL stall_done got=%h want=%h", obsC, {3'b001, 48'd0});
        end
        nextCycle();
        for (int rep = 0; rep < 4; rep++) begin
            ifC.start = 1'b1;
            nextCycle();
            ifC.start = 1'b0;
            pts = 0;
            for (int it = 0; it < 60 && pts < 4; it++) begin
                s = (it < 30) ? ($urandom_range(0, 2) == 0) : 1'b0;
                ifC.stall = s;
                #1;
                e = {~s, 1'b1, 1'b0, 32'd0, 16'(pts)};
                total++;
                if (obsC !== e) begin
                    bad++;
                    $display("[TB] FAIL stall_random rep=%0d got=%h want=%h", rep, obsC, e);
                end
                if (!s) pts++;
                nextCycle();
            end
            ifC.stall = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (obsC !== {3'b001, 48'd0}) begin
                bad++;
                $display("[TB] FAIL stall_random_done rep=%0d got=%h", rep, obsC);
            end
            ifC.stall = 1'b0;
            nextCycle();
        end
    endtask
`endif

    initial begin
        ifA.start = 1'b0;
        ifA.flush = 1'b0;
        ifB.start = 1'b0;
        ifB.flush = 1'b0;
`ifdef CTRL_STALL_EN
        ifA.stall = 1'b0;
        ifB.stall = 1'b0;
        ifC.start = 1'b0;
        ifC.flush = 1'b0;
        ifC.stall = 1'b0;
`endif
        test_reset();
        test_single_traversal();
        test_delayed_start();
        test_ignored_start();
        test_flush();
        test_async_reset();
        test_random();
`ifdef CTRL_STALL_EN
        test_stall();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
